// File: rtl/drum_voice_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : drum_voice_arbiter
// Description : Shares one tone voice among four debounced drum pads using
//               round-robin grants, per-pad note length and a silence gap.
//               Optional macro PREEMPT_EN lets a lower-index pad cut a note.
// Revision    : 1.0  initial release
// ============================================================================
module drum_voice_arbiter #(
    parameter int DEBOUNCE = 16,
    parameter int HOLD0    = 2048,
    parameter int HOLD1    = 8192,
    parameter int HOLD2    = 8192,
    parameter int HOLD3    = 16384,
    parameter int GAP_LEN  = 64
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [3:0] drum,
    output logic [7:0] note,
    output logic       note_valid,
    output logic [1:0] active_pad,
    output logic       grant,
    output logic       busy,
    output logic [3:0] led
);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_play  = 2'd1;
    localparam logic [1:0]  c_st_gap   = 2'd2;
    localparam logic [7:0]  c_db_last  = 8'(DEBOUNCE - 1);
    localparam logic [14:0] c_hold0_m1 = 15'(HOLD0 - 1);
    localparam logic [14:0] c_hold1_m1 = 15'(HOLD1 - 1);
    localparam logic [14:0] c_hold2_m1 = 15'(HOLD2 - 1);
    localparam logic [14:0] c_hold3_m1 = 15'(HOLD3 - 1);
    localparam logic [14:0] c_gap_m1   = (GAP_LEN == 0) ? 15'd0 : 15'(GAP_LEN - 1);

    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [3:0]  w_level;
    logic [3:0]  r_level_q;
    logic [3:0]  w_rise;
    logic [3:0]  r_pending;
    logic [3:0]  w_grant_onehot;
    logic [1:0]  r_state;
    logic [1:0]  w_state_nx;
    logic [14:0] r_cnt;
    logic [14:0] w_cnt_nx;
    logic [14:0] w_hold_m1;
    logic [1:0]  r_ptr;
    logic [7:0]  r_note;
    logic        r_valid;
    logic        w_valid_nx;
    logic [1:0]  r_active;
    logic        r_grant;
    logic        w_do_grant;
    logic [1:0]  w_grant_idx;
    logic        w_rr_found;
    logic [1:0]  w_rr_idx;
    logic [1:0]  w_cand;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 4'd0;
            r_sync2   <= 4'd0;
            r_level_q <= 4'd0;
        end else begin
            r_sync1   <= drum;
            r_sync2   <= r_sync1;
            r_level_q <= w_level;
        end
    end

    generate
        for (genvar i = 0; i < 4; i++) begin : g_pad
            logic [7:0] r_db_cnt;
            logic       r_lvl;

            always_ff @(posedge sysclk or negedge rst_n) begin
                if (!rst_n) begin
                    r_db_cnt <= 8'd0;
                    r_lvl    <= 1'b0;
                end else if (r_sync2[i] == r_lvl) begin
                    r_db_cnt <= 8'd0;
                end else if (r_db_cnt == c_db_last) begin
                    r_lvl    <= r_sync2[i];
                    r_db_cnt <= 8'd0;
                end else begin
                    r_db_cnt <= r_db_cnt + 8'd1;
                end
            end

            assign w_level[i] = r_lvl;
        end
    endgenerate

    assign w_rise = w_level & ~r_level_q;

    // Round-robin search starting just after the last granted pad.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = r_ptr;
        w_cand     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_rr_found && r_pending[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end
        end
    end

`ifdef PREEMPT_EN
    logic       w_pre_found;
    logic [1:0] w_pre_idx;

    // Lowest-index pending pad below the one playing; descending loop keeps the lowest.
    always_comb begin
        w_pre_found = 1'b0;
        w_pre_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (r_pending[k] && (2'(k) < r_active)) begin
                w_pre_found = 1'b1;
                w_pre_idx   = 2'(k);
            end
        end
    end
`endif

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_valid_nx  = r_valid;
        w_do_grant  = 1'b0;
        w_grant_idx = w_rr_idx;
        case (r_state)
            c_st_idle: begin
                if (w_rr_found) w_do_grant = 1'b1;
            end
            c_st_play: begin
`ifdef PREEMPT_EN
                if (w_pre_found) begin
                    w_do_grant  = 1'b1;
                    w_grant_idx = w_pre_idx;
                end else
`endif
                if (r_cnt != 15'd0) begin
                    w_cnt_nx = r_cnt - 15'd1;
                end else if (GAP_LEN != 0) begin
                    w_state_nx = c_st_gap;
                    w_cnt_nx   = c_gap_m1;
                    w_valid_nx = 1'b0;
                end else if (w_rr_found) begin
                    w_do_grant = 1'b1;
                end else begin
                    w_state_nx = c_st_idle;
                    w_valid_nx = 1'b0;
                end
            end
            c_st_gap: begin
                if (r_cnt != 15'd0) begin
                    w_cnt_nx = r_cnt - 15'd1;
                end else if (w_rr_found) begin
                    w_do_grant = 1'b1;
                end else begin
                    w_state_nx = c_st_idle;
                end
            end
            default: begin
                w_state_nx = c_st_idle;
                w_valid_nx = 1'b0;
            end
        endcase
        if (w_do_grant) begin
            w_state_nx = c_st_play;
            w_cnt_nx   = w_hold_m1;
            w_valid_nx = 1'b1;
        end
    end

    always_comb begin
        w_hold_m1 = c_hold0_m1;
        case (w_grant_idx)
            2'd0:    w_hold_m1 = c_hold0_m1;
            2'd1:    w_hold_m1 = c_hold1_m1;
            2'd2:    w_hold_m1 = c_hold2_m1;
            default: w_hold_m1 = c_hold3_m1;
        endcase
    end

    assign w_grant_onehot = w_do_grant ? (4'b0001 << w_grant_idx) : 4'b0000;

    // A fresh rise in the grant cycle survives the clear so no hit is lost.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_cnt     <= 15'd0;
            r_valid   <= 1'b0;
            r_grant   <= 1'b0;
            r_pending <= 4'd0;
            r_note    <= 8'd0;
            r_active  <= 2'd0;
            r_ptr     <= 2'd0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_valid   <= w_valid_nx;
            r_grant   <= w_do_grant;
            r_pending <= (r_pending & ~w_grant_onehot) | w_rise;
            if (w_do_grant) begin
                r_note   <= {5'd0, w_grant_idx, 1'b0} + 8'd2;
                r_active <= w_grant_idx;
                r_ptr    <= w_grant_idx + 2'd1;
            end
        end
    end

    assign note       = r_note;
    assign note_valid = r_valid;
    assign active_pad = r_active;
    assign grant      = r_grant;
    assign busy       = (r_state != c_st_idle);
    assign led        = w_level;

endmodule
`default_nettype wire

// File: doc/drum_voice_arbiter.md
Name: drum_voice_arbiter

Overview:
- Shares the single tone generator (note-ROM / divider / speaker path) among the four drum pads.
- Synchronises and debounces raw pad inputs, then latches each hit as a pending request.
- Grants the voice to one pad at a time, round-robin. Holds each note for a per-pad duration, then inserts a silence gap.
- Outputs a registered note code, a valid flag and LED status to the tone datapath downstream.

Parameters:
DEBOUNCE, 16, consecutive stable cycles required before the debounced level changes (1..255)
HOLD0, 2048, note duration in sysclk cycles for pad 0 (1..32767)
HOLD1, 8192, note duration for pad 1
HOLD2, 8192, note duration for pad 2
HOLD3, 16384, note duration for pad 3
GAP_LEN, 64, silence cycles between consecutive notes (0..255; 0 = no gap)

Ports:
sysclk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
drum  in  4  raw pad inputs, asynchronous, active-high
note  out  8  note code to ROM/divider: pad i -> 2*(i+1), i.e. 2, 4, 6, 8
note_valid  out  1  high while a note is playing; gates the speaker toggle
active_pad  out  2  index of the granted pad
grant  out  1  one-cycle pulse on each new grant
busy  out  1  FSM not in IDLE
led  out  4  debounced pad levels

Behaviour:
- Reset, asynchronous on rst_n low:
  - Outputs: note=0, note_valid=0, active_pad=0, grant=0, busy=0, led=0.
  - Internal: sync flops, debounce counters and levels, pending flags all 0; RR pointer=0; state=IDLE.
- Reset mid-note: everything returns to reset values immediately. Pending hits are discarded.
- Sync and debounce:
  - 2-flop synchroniser per pad.
  - Per-pad counter increments while the synced value differs from the debounced level, and clears on a match.
  - When the counter reaches DEBOUNCE, the debounced level takes the synced value and the counter clears.
- Edge detection: a debounced 0->1 transition sets pending[i] on the next edge. Repeat hits while pending coalesce into one request.
- A hit on the pad currently playing sets pending, so the pad retriggers after the gap.
- A pending flag clears on the cycle its grant is issued.
- Arbitration: round-robin. Search starts at (last granted pad + 1) mod 4; after reset it starts at 0. Only pending pads are eligible.
- FSM states: IDLE, PLAY, GAP.
  - IDLE: if any pending, the next edge does all of the following, then enters PLAY: grant=1, note and active_pad loaded, note_valid=1, counter = HOLDk-1.
  - PLAY: counter decrements each cycle. When the counter is 0, the next edge goes to GAP with counter = GAP_LEN-1 and note_valid=0; note and active_pad hold their values. If GAP_LEN=0, it behaves as if GAP expired immediately.
  - GAP: counter decrements. When it is 0, the next edge grants a pending pad and returns to PLAY, or goes to IDLE if none is pending.
- Note length: note_valid is high for exactly HOLDk cycles per grant.
- Latency: a raw rise held stable produces note_valid at edge 4+DEBOUNCE when IDLE (2 sync + DEBOUNCE + 1 pending + 1 grant).
- Simultaneous pending requests resolve by the RR pointer only. A pad release has no effect on an active note.
- busy = (state != IDLE). led = debounced levels.

Optional Feature:
PREEMPT_EN
- Defined: in PLAY, if pending holds a pad with a lower index than active_pad (pad 0 highest), the next edge does the following with no gap:
  - grants that pad immediately (grant=1), reloads the counter with its HOLD, and keeps note_valid=1;
  - drops the preempted pad; it is not re-queued.
- Undefined: no preemption. Requests wait for PLAY+GAP to finish.

Test Plan (DEBOUNCE=4, HOLD0..3=10,20,30,40, GAP_LEN=3 unless stated):
- Reset then a single drum[2] rise held: note_valid rises at edge 8; note=6, active_pad=2, grant pulses once; note_valid high 30 cycles, then 3 gap cycles, then IDLE with busy=0.
- Glitch: drum[0] high for 3 cycles only -> led stays 0, no pending, no grant.
- drum[0] and drum[3] rise together -> pad 0 plays (note=2, 10 cycles), gap 3, then pad 3 plays (note=8, 40 cycles); pointer moves to 0.
- Retrigger drum[1] during its own note -> after its 20 cycles + 3 gap cycles a second grant with note=4; a third hit mid-note only coalesces, giving one extra grant.
- GAP_LEN=0 with pads 1 and 2 pending -> note_valid stays high across the switch, and grant pulses at the boundary.
- Assert rst_n low mid-PLAY with a pad pending -> outputs are 0 at once; after release, no note plays until a new hit.
